// File: rtl/frame_receiver_pkg.sv
// Shared router package: frame geometry defaults, receiver state encoding
// and the width of the optional statistics counters.
package frame_receiver_pkg;

    localparam int unsigned FR_ADDR_W    = 4;
    localparam int unsigned FR_PAYLOAD_W = 32;
    localparam int unsigned FR_STATS_W   = 16;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ADDR      = 2'd2,
        DATA      = 2'd3
    } fr_state_e;

endpackage

// File: rtl/frame_receiver_sat_counter.sv
// Saturating event counter.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high clear
//   inc    - count one event this cycle
//   count  - current value, sticks at all-ones
module sat_counter
    import frame_receiver_pkg::*;
#(
    parameter int unsigned W = FR_STATS_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/frame_receiver.sv
// Serial frame receiver for one router port. Deserializes an LSB-first
// address + fixed-length payload framed by active-low frame_n/valid_n and
// pushes each good frame to the port FIFO with a one-cycle vld strobe.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   frame_n, valid_n    - active-low frame envelope and payload-bit qualifier
//   di                  - serial data, LSB first
//   full                - downstream FIFO full, sampled in the terminating cycle
//   addr, payload       - last accepted frame (change only with vld)
//   vld, err, drop      - one-cycle pulses: pushed / malformed / lost to full
// Option FRAME_RX_STATS_EN adds ok_cnt/err_cnt/drop_cnt saturating counters.
module frame_receiver
    import frame_receiver_pkg::*;
#(
    parameter int unsigned ADDR_W    = FR_ADDR_W,
    parameter int unsigned PAYLOAD_W = FR_PAYLOAD_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_n,
    input  logic                  valid_n,
    input  logic                  di,
    input  logic                  full,
    output logic [ADDR_W-1:0]     addr,
    output logic [PAYLOAD_W-1:0]  payload,
    output logic                  vld,
    output logic                  err,
    output logic                  drop
`ifdef FRAME_RX_STATS_EN
    ,
    output logic [FR_STATS_W-1:0] ok_cnt,
    output logic [FR_STATS_W-1:0] err_cnt,
    output logic [FR_STATS_W-1:0] drop_cnt
`endif
);

    // Sized to hold PAYLOAD_W itself plus the terminating bit, so it never wraps.
    localparam int unsigned CNT_W = $clog2(PAYLOAD_W + 2);

    fr_state_e              state;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_W-1:0]      addr_sh;
    logic [PAYLOAD_W-1:0]   payload_sh;

    logic [CNT_W-1:0]       cnt_term_c;
    logic [PAYLOAD_W-1:0]   payload_fin_c;

    // Bits are shifted in from the top, so after exactly W shifts the first
    // (LSB) bit sits at position 0. The terminating cycle may carry the last bit.
    always_comb begin
        cnt_term_c    = cnt + CNT_W'(!valid_n);
        payload_fin_c = valid_n ? payload_sh : {di, payload_sh[PAYLOAD_W-1:1]};
    end

    // Receive FSM with datapath and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= WAIT_IDLE;
            cnt        <= '0;
            addr_sh    <= '0;
            payload_sh <= '0;
            addr       <= '0;
            payload    <= '0;
            vld        <= 1'b0;
            err        <= 1'b0;
            drop       <= 1'b0;
        end else begin
            vld  <= 1'b0;
            err  <= 1'b0;
            drop <= 1'b0;
            case (state)
                // Wait for a frame gap so a frame tail is never captured.
                WAIT_IDLE: begin
                    if (frame_n) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!frame_n) begin
                        addr_sh <= {di, addr_sh[ADDR_W-1:1]};
                        cnt     <= CNT_W'(1);
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (frame_n) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= WAIT_IDLE;
                    end else begin
                        addr_sh <= {di, addr_sh[ADDR_W-1:1]};
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            cnt   <= '0;
                            state <= DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (frame_n) begin
                        if (cnt_term_c == CNT_W'(PAYLOAD_W)) begin
                            if (full) begin
                                drop <= 1'b1;
                            end else begin
                                vld     <= 1'b1;
                                addr    <= addr_sh;
                                payload <= payload_fin_c;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (!valid_n) begin
                        if (cnt == CNT_W'(PAYLOAD_W)) begin
                            err   <= 1'b1;
                            cnt   <= '0;
                            state <= WAIT_IDLE;
                        end else begin
                            payload_sh <= {di, payload_sh[PAYLOAD_W-1:1]};
                            cnt        <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_RX_STATS_EN
    sat_counter #(.W(FR_STATS_W)) u_ok_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (vld),
        .count (ok_cnt)
    );

    sat_counter #(.W(FR_STATS_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (err),
        .count (err_cnt)
    );

    sat_counter #(.W(FR_STATS_W)) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop),
        .count (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Self-checking bench for frame_receiver: directed frames plus randomized
// frames, each classified by a frame-level outcome model (good, short,
// overlong, runt, dropped) and checked cycle by cycle.
module tb_frame_receiver;

    logic        clock;
    logic        reset;
    logic        frame_n;
    logic        valid_n;
    logic        di;
    logic        full;
    logic [3:0]  addr;
    logic [31:0] payload;
    logic        vld;
    logic        err;
    logic        drop;
`ifdef FRAME_RX_STATS_EN
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;
`endif

    int          checks;
    int          failures;
    logic [3:0]  exp_addr;
    logic [31:0] exp_payload;
    int          ok_m;
    int          err_m;
    int          drop_m;

    frame_receiver dut (
        .clock    (clock),
        .reset    (reset),
        .frame_n  (frame_n),
        .valid_n  (valid_n),
        .di       (di),
        .full     (full),
        .addr     (addr),
        .payload  (payload),
        .vld      (vld),
        .err      (err),
        .drop     (drop)
`ifdef FRAME_RX_STATS_EN
        ,
        .ok_cnt   (ok_cnt),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, let the edge happen, check the registered response.
    task automatic step(input logic fn, input logic vn, input logic d, input logic f,
                        input logic r, input logic ev, input logic ee, input logic ed);
        frame_n = fn;
        valid_n = vn;
        di      = d;
        full    = f;
        reset   = r;
        @(posedge clock);
        #1;
        if (r) begin
            exp_addr    = '0;
            exp_payload = '0;
            ok_m        = 0;
            err_m       = 0;
            drop_m      = 0;
        end else begin
            ok_m   += int'(ev);
            err_m  += int'(ee);
            drop_m += int'(ed);
        end
        chk("vld", 32'(vld), 32'(ev));
        chk("err", 32'(err), 32'(ee));
        chk("drop", 32'(drop), 32'(ed));
        chk("addr", 32'(addr), 32'(exp_addr));
        chk("payload", payload, exp_payload);
    endtask

    // Sends one frame of nbits payload bits (nbits==0: runt ending in the
    // address phase) with pad_len padding cycles before payload bit pad_at.
    // Outcome: exactly 32 bits -> push (or drop when full at the end);
    // fewer -> err at the end; 33rd bit -> err there and the rest is ignored.
    task automatic run_frame(input logic [3:0] a, input logic [63:0] bits, input int nbits,
                             input int pad_at, input int pad_len, input logic f_term,
                             input int gap);
        logic fn_i;
        logic last;
        logic complete;
        logic ee;
        for (int i = 0; i < 4; i++) begin
            fn_i = (nbits == 0) && (i == 3);
            step(fn_i, 1'($urandom), a[i], 1'($urandom), 1'b0, 1'b0, fn_i, 1'b0);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == pad_at) begin
                for (int p = 0; p < pad_len; p++) begin
                    step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
            last     = (i == nbits - 1);
            complete = last && (nbits == 32);
            ee       = (i == 32) || (last && (nbits < 32));
            if (complete && !f_term) begin
                exp_addr    = a;
                exp_payload = bits[31:0];
            end
            step(last, 1'b0, bits[i], last ? f_term : 1'($urandom), 1'b0,
                 complete && !f_term, ee, complete && f_term);
        end
        for (int g = 0; g < gap; g++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk_stats();
`ifdef FRAME_RX_STATS_EN
        chk("ok_cnt", 32'(ok_cnt), 32'(ok_m));
        chk("err_cnt", 32'(err_cnt), 32'(err_m));
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_m));
`endif
    endtask

    initial begin
        int nb;
        int sel;
        int gap;
        logic [63:0] rb;
        checks      = 0;
        failures    = 0;
        exp_addr    = '0;
        exp_payload = '0;
        ok_m        = 0;
        err_m       = 0;
        drop_m      = 0;

        // Reset state.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Good frame, then the same frame with padding, back to back.
        run_frame(4'hA, 64'hDEADBEEF, 32, 99, 0, 1'b0, 0);
        run_frame(4'hA, 64'hDEADBEEF, 32, 16, 3, 1'b0, 1);
        // Short frame: err, outputs hold.
        run_frame(4'h3, 64'h12345678, 31, 99, 0, 1'b0, 0);
        // 33-bit and longer frames, each followed by an accepted frame.
        run_frame(4'h7, 64'h1_8765_4321, 33, 99, 0, 1'b0, 0);
        run_frame(4'h5, 64'h0F0F1234, 32, 99, 0, 1'b0, 0);
        run_frame(4'h9, 64'hFF_FFFF_FFFF, 40, 5, 2, 1'b0, 0);
        run_frame(4'h1, 64'h89ABCDEF, 32, 0, 1, 1'b0, 1);
        // Runt frame, then a frame dropped on full.
        run_frame(4'hC, 64'h0, 0, 99, 0, 1'b0, 1);
        run_frame(4'h6, 64'hCAFEF00D, 32, 99, 0, 1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats();

        // Randomized frames.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 6)      nb = int'($urandom_range(1, 31));
            else if (sel == 7) nb = int'($urandom_range(33, 40));
            else if (sel == 8) nb = 0;
            else               nb = 32;
            gap = (nb == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            rb  = {$urandom, $urandom};
            run_frame(4'($urandom), rb, nb, int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), gap);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_stats();

        // Reset at payload bit 10 while frame_n stays low for 20 more cycles.
        run_frame(4'hB, 64'h13572468, 32, 99, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(4'h4, 64'hA5A55A5A, 32, 8, 2, 1'b0, 2);
        chk_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
